// File: rtl/pas_predictor_updater.sv
// rtl/pas_predictor_updater.sv - PAs predictor write side: update queue plus 3-stage BHT/PHT read-modify-write pipeline
module pas_predictor_updater #(
  parameter int COMMIT_WIDTH  = 2,
  parameter int PC_WIDTH      = 32,
  parameter int BHT_ENTRY_NUM = 1024,
  parameter int PHT_ENTRY_NUM = 2048,
  parameter int HISTORY_WIDTH = 5,
  parameter int QUEUE_DEPTH   = 8,
  localparam int BHT_IDX_W    = $clog2(BHT_ENTRY_NUM),
  localparam int PHT_IDX_W    = $clog2(PHT_ENTRY_NUM),
  localparam int PC_LO_W      = PHT_IDX_W - HISTORY_WIDTH,
  localparam int QPTR_W       = $clog2(QUEUE_DEPTH),
  localparam int KEY_W        = (BHT_IDX_W > PC_LO_W) ? BHT_IDX_W : PC_LO_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [COMMIT_WIDTH-1:0]                upd_valid,
  input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0]  upd_pc,
  input  logic [COMMIT_WIDTH-1:0]                upd_taken,
  output logic                                   upd_ready,
  output logic                                   bht_rd_en,
  output logic [BHT_IDX_W-1:0]                   bht_rd_idx,
  input  logic [HISTORY_WIDTH-1:0]               bht_rd_data,
  output logic                                   bht_wr_en,
  output logic [BHT_IDX_W-1:0]                   bht_wr_idx,
  output logic [HISTORY_WIDTH-1:0]               bht_wr_data,
  output logic                                   pht_rd_en,
  output logic [PHT_IDX_W-1:0]                   pht_rd_idx,
  input  logic [1:0]                             pht_rd_data,
  output logic                                   pht_wr_en,
  output logic [PHT_IDX_W-1:0]                   pht_wr_idx,
  output logic [1:0]                             pht_wr_data,
  output logic                                   busy
);

  localparam logic [QPTR_W:0] DEPTH_C = (QPTR_W+1)'(QUEUE_DEPTH);
  localparam logic [QPTR_W:0] CW_C    = (QPTR_W+1)'(COMMIT_WIDTH);

  // Queue keeps only the PC bits that feed either index.
  logic [KEY_W-1:0]        r_q_key [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  r_q_taken;
  logic [QPTR_W-1:0]       r_wr_ptr;
  logic [QPTR_W-1:0]       r_rd_ptr;
  logic [QPTR_W:0]         r_count;

  logic                    r_s1_valid;
  logic [BHT_IDX_W-1:0]    r_s1_bidx;
  logic [PC_LO_W-1:0]      r_s1_pclo;
  logic                    r_s1_taken;

  logic                    r_s2_valid;
  logic [BHT_IDX_W-1:0]    r_s2_bidx;
  logic [PHT_IDX_W-1:0]    r_s2_pidx;
  logic                    r_s2_taken;

  logic                    r_lw_valid;
  logic [BHT_IDX_W-1:0]    r_lw_bidx;
  logic [HISTORY_WIDTH-1:0] r_lw_hist;
  logic [PHT_IDX_W-1:0]    r_lw_pidx;
  logic [1:0]              r_lw_ctr;

  logic [QPTR_W:0]         w_free;
  logic [QPTR_W:0]         w_enq_cnt;
  logic [QPTR_W-1:0]       w_slot [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] w_lane_en;
  logic                    w_pop;
  logic [KEY_W-1:0]        w_head_key;
  logic                    w_head_taken;
  logic [HISTORY_WIDTH-1:0] w_s1_hist;
  logic [PHT_IDX_W-1:0]    w_s1_pidx;
  logic [1:0]              w_s2_ctr_old;
  logic [1:0]              w_s2_ctr_new;
  logic [HISTORY_WIDTH-1:0] w_s2_hist_new;
  logic                    w_unused_pc;

  assign w_unused_pc = ^upd_pc;

  assign w_free    = DEPTH_C - r_count;
  assign upd_ready = !rst && (w_free >= CW_C);

  // Compact valid lanes into consecutive slots, lowest lane first.
  always_comb begin
    w_enq_cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_lane_en[i] = upd_ready && upd_valid[i];
      w_slot[i]    = r_wr_ptr + w_enq_cnt[QPTR_W-1:0];
      if (w_lane_en[i]) begin
        w_enq_cnt = w_enq_cnt + {{QPTR_W{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (w_lane_en[i]) begin
        r_q_key[w_slot[i]]   <= upd_pc[i][2 +: KEY_W];
        r_q_taken[w_slot[i]] <= upd_taken[i];
      end
    end
  end

  assign w_pop        = (r_count != '0);
  assign w_head_key   = r_q_key[r_rd_ptr];
  assign w_head_taken = r_q_taken[r_rd_ptr];

  // S1 history: in-flight S2 write beats last-cycle write beats RAM.
  always_comb begin
    w_s1_hist = bht_rd_data;
    if (r_s2_valid && (r_s2_bidx == r_s1_bidx)) begin
      w_s1_hist = w_s2_hist_new;
    end else if (r_lw_valid && (r_lw_bidx == r_s1_bidx)) begin
      w_s1_hist = r_lw_hist;
    end
  end

  assign w_s1_pidx = {w_s1_hist, r_s1_pclo};

  // The only PHT write the RAM read can miss is the one issued the cycle it was read.
  always_comb begin
    w_s2_ctr_old = pht_rd_data;
    if (r_lw_valid && (r_lw_pidx == r_s2_pidx)) begin
      w_s2_ctr_old = r_lw_ctr;
    end
    if (r_s2_taken) begin
      w_s2_ctr_new = (w_s2_ctr_old == 2'd3) ? 2'd3 : w_s2_ctr_old + 2'd1;
    end else begin
      w_s2_ctr_new = (w_s2_ctr_old == 2'd0) ? 2'd0 : w_s2_ctr_old - 2'd1;
    end
  end

  assign w_s2_hist_new = {r_s2_pidx[PHT_IDX_W-2 -: HISTORY_WIDTH-1], r_s2_taken};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_lw_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + w_enq_cnt[QPTR_W-1:0];
      r_rd_ptr   <= r_rd_ptr + {{(QPTR_W-1){1'b0}}, w_pop};
      r_count    <= r_count + w_enq_cnt - {{QPTR_W{1'b0}}, w_pop};
      r_s1_valid <= w_pop;
      r_s2_valid <= r_s1_valid;
      r_lw_valid <= r_s2_valid;
    end
    r_s1_bidx  <= w_head_key[BHT_IDX_W-1:0];
    r_s1_pclo  <= w_head_key[PC_LO_W-1:0];
    r_s1_taken <= w_head_taken;
    r_s2_bidx  <= r_s1_bidx;
    r_s2_pidx  <= w_s1_pidx;
    r_s2_taken <= r_s1_taken;
    r_lw_bidx  <= r_s2_bidx;
    r_lw_hist  <= w_s2_hist_new;
    r_lw_pidx  <= r_s2_pidx;
    r_lw_ctr   <= w_s2_ctr_new;
  end

  assign bht_rd_en   = w_pop && !rst;
  assign bht_rd_idx  = w_head_key[BHT_IDX_W-1:0];
  assign pht_rd_en   = r_s1_valid && !rst;
  assign pht_rd_idx  = w_s1_pidx;
  assign bht_wr_en   = r_s2_valid && !rst;
  assign bht_wr_idx  = r_s2_bidx;
  assign bht_wr_data = w_s2_hist_new;
  assign pht_wr_en   = r_s2_valid && !rst;
  assign pht_wr_idx  = r_s2_pidx;
  assign pht_wr_data = w_s2_ctr_new;
  assign busy        = !rst && (w_pop || r_s1_valid || r_s2_valid);

endmodule
